// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and the
// {pc, inst} entry carried through the skid buffer to decode.
package fetch_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} fetch_state_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetched {pc, inst} pairs; the head is exposed straight
// from registers so decode sees stable data while it stalls.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t entry_reg [2];
  logic         rd_ptr_reg;
  logic         wr_ptr_reg;
  logic [1:0]   count_reg;
  logic         do_push;
  logic         do_pop;

  // A flush discards everything, including a word arriving the same cycle.
  assign do_push = push & ~flush;
  assign do_pop  = pop & (count_reg != 2'd0) & ~flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg[gi] <= push_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_entry = entry_reg[rd_ptr_reg];
  assign head_valid = (count_reg != 2'd0);
  assign count      = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues reads to a one-cycle
// synchronous instruction memory, buffers returns and handles redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_pc,
  input  logic [31:0] im_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fault
);

  localparam logic [31:0] MEM_LIMIT = 32'(IMEM_WORDS * WORD_BYTES);
  localparam logic [2:0]  DEPTH     = 3'(BUF_DEPTH);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic         inflight_reg, inflight_next;
  logic [31:0]  inflight_pc_reg, inflight_pc_next;
  logic         fault_reg, fault_next;

  logic         pop;
  logic         push;
  logic         flush;
  logic [1:0]   buf_count;
  logic [2:0]   occupancy;
  logic         redirect_legal;
  fetch_entry_t head_entry;
  fetch_entry_t push_entry;

  assign pop            = out_valid & out_ready;
  assign push_entry     = '{pc: inflight_pc_reg, inst: im_inst};
  // Entries that will be held after this edge, counting the word in flight.
  assign occupancy      = {1'b0, buf_count} + {2'b0, inflight_reg} - {2'b0, pop};
  assign redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc < MEM_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      fault_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      fault_reg       <= fault_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    inflight_next    = 1'b0;
    inflight_pc_next = inflight_pc_reg;
    fault_next       = fault_reg;
    push             = 1'b0;
    flush            = 1'b0;

    if (redirect_valid) begin
      flush = 1'b1;
      if (redirect_legal) begin
        fetch_pc_next = redirect_pc;
        fault_next    = 1'b0;
        state_next    = RUN;
      end else begin
        fault_next = 1'b1;
        state_next = HALT;
      end
    end else begin
      push = inflight_reg;
      unique case (state_reg)
        RUN: begin
          if (fetch_pc_reg >= MEM_LIMIT) begin
            state_next = DRAIN;
          end else if (occupancy < DEPTH) begin
            inflight_next    = 1'b1;
            inflight_pc_next = fetch_pc_reg;
            fetch_pc_next    = fetch_pc_reg + 32'(WORD_BYTES);
          end
        end
        DRAIN: begin
          if ((buf_count == 2'd0) && !inflight_reg) begin
            state_next = HALT;
            fault_next = 1'b1;
          end
        end
        HALT: begin
        end
        default: begin
          state_next = HALT;
        end
      endcase
    end
  end

  fetch_skid_buf u_skid_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .head_valid (out_valid),
    .count      (buf_count)
  );

  assign im_pc    = fetch_pc_reg;
  assign out_inst = head_entry.inst;
  assign out_pc   = head_entry.pc;
  assign fault    = fault_reg;

endmodule
